// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and types for the operand fetch stage.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with set/clear/flush-clear and three busy lookups.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush_clr_en,
    input  logic [ADDR_W-1:0] flush_clr_addr,
    input  logic [ADDR_W-1:0] query_addr_1,
    input  logic [ADDR_W-1:0] query_addr_2,
    input  logic [ADDR_W-1:0] query_addr_3,
    output logic              busy_1,
    output logic              busy_2,
    output logic              busy_3
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clears are applied before the set so a same-cycle set on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (flush_clr_en) begin
            pending_d[flush_clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy_1 = pending_q[query_addr_1];
    assign busy_2 = pending_q[query_addr_2];
    assign busy_3 = pending_q[query_addr_3];

endmodule

// File: rtl/reg_operand_fetch.sv
// rtl/reg_operand_fetch.sv - operand fetch with hazard stall and one-deep output stage.
// REG_OPERAND_FETCH_FORWARD_EN enables same-cycle writeback bypass; default build stalls through writeback.
module reg_operand_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_src1,
    input  logic [ADDR_W-1:0] in_src2,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_dst_we,
    output logic [ADDR_W-1:0] rf_read_addr_1,
    output logic [ADDR_W-1:0] rf_read_addr_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_dst,
    output logic              out_dst_we
);

    logic      busy_1, busy_2, busy_dst;
    logic      wb_hit_1, wb_hit_2, wb_hit_dst;
    logic      src1_nz, src2_nz, dst_nz;
    logic      haz_1, haz_2, waw;
    logic      accept;
    word_t     op1, op2;

    logic      out_valid_q, out_valid_d;
    word_t     out_op1_q, out_op1_d;
    word_t     out_op2_q, out_op2_d;
    reg_addr_t out_dst_q, out_dst_d;
    logic      out_dst_we_q, out_dst_we_d;

    assign rf_read_addr_1 = in_src1;
    assign rf_read_addr_2 = in_src2;

    assign src1_nz    = (in_src1 != '0);
    assign src2_nz    = (in_src2 != '0);
    assign dst_nz     = (in_dst != '0);
    assign wb_hit_1   = wb_valid && (wb_dest == in_src1);
    assign wb_hit_2   = wb_valid && (wb_dest == in_src2);
    assign wb_hit_dst = wb_valid && (wb_dest == in_dst);

`ifdef REG_OPERAND_FETCH_FORWARD_EN
    assign haz_1 = src1_nz && busy_1 && !wb_hit_1;
    assign haz_2 = src2_nz && busy_2 && !wb_hit_2;
    assign waw   = in_dst_we && dst_nz && busy_dst && !wb_hit_dst;
    assign op1   = !src1_nz ? '0 : (wb_hit_1 ? wb_data : rf_read_data_1);
    assign op2   = !src2_nz ? '0 : (wb_hit_2 ? wb_data : rf_read_data_2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    // Without bypass the value is only visible in the register file one cycle after writeback.
    assign haz_1 = src1_nz && (busy_1 || wb_hit_1);
    assign haz_2 = src2_nz && (busy_2 || wb_hit_2);
    assign waw   = in_dst_we && dst_nz && (busy_dst || wb_hit_dst);
    assign op1   = src1_nz ? rf_read_data_1 : '0;
    assign op2   = src2_nz ? rf_read_data_2 : '0;
`endif

    assign in_ready = !flush && (!out_valid_q || out_ready) && !haz_1 && !haz_2 && !waw;
    assign accept   = in_valid && in_ready;

    reg_scoreboard u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .set_en         (accept && in_dst_we && dst_nz),
        .set_addr       (in_dst),
        .clr_en         (wb_valid),
        .clr_addr       (wb_dest),
        .flush_clr_en   (flush && out_valid_q && out_dst_we_q && (out_dst_q != '0)),
        .flush_clr_addr (out_dst_q),
        .query_addr_1   (in_src1),
        .query_addr_2   (in_src2),
        .query_addr_3   (in_dst),
        .busy_1         (busy_1),
        .busy_2         (busy_2),
        .busy_3         (busy_dst)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_op1_d    = out_op1_q;
        out_op2_d    = out_op2_q;
        out_dst_d    = out_dst_q;
        out_dst_we_d = out_dst_we_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_op1_d    = op1;
            out_op2_d    = op2;
            out_dst_d    = in_dst;
            out_dst_we_d = in_dst_we;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_dst_q    <= '0;
            out_dst_we_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_dst_q    <= out_dst_d;
            out_dst_we_q <= out_dst_we_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op1    = out_op1_q;
    assign out_op2    = out_op2_q;
    assign out_dst    = out_dst_q;
    assign out_dst_we = out_dst_we_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// tb/tb_reg_operand_fetch.sv - directed and randomized bench for reg_operand_fetch against an array model.
module tb_reg_operand_fetch;
    import cpu_pkg::*;

`ifdef REG_OPERAND_FETCH_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst;
    logic      flush, in_valid, in_ready, in_dst_we;
    logic      wb_valid, out_valid, out_ready, out_dst_we;
    reg_addr_t in_src1, in_src2, in_dst, rf_read_addr_1, rf_read_addr_2, wb_dest, out_dst;
    word_t     rf_read_data_1, rf_read_data_2, wb_data, out_op1, out_op2;

    word_t     rf [NUM_REGS];
    bit        pend [NUM_REGS];
    bit        m_valid, m_we;
    word_t     m_op1, m_op2;
    reg_addr_t m_dst;
    int        total = 0;
    int        bad   = 0;

    assign rf_read_data_1 = rf[rf_read_addr_1];
    assign rf_read_data_2 = rf[rf_read_addr_2];

    always #5 clk = ~clk;

    reg_operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_dst_we(in_dst_we),
        .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst), .out_dst_we(out_dst_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit blocked(input reg_addr_t r);
        bit wb_now;
        wb_now = wb_valid && (wb_dest == r);
        if (r == 0) return 1'b0;
        if (FWD) return pend[r] && !wb_now;
        return pend[r] || wb_now;
    endfunction

    function automatic word_t operand(input reg_addr_t r);
        if (r == 0) return '0;
        if (FWD && wb_valid && wb_dest == r) return wb_data;
        return rf[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
        m_valid = 1'b0; m_we = 1'b0; m_op1 = '0; m_op2 = '0; m_dst = '0;
    endtask

    task automatic drive(input bit v, input reg_addr_t s1, input reg_addr_t s2, input reg_addr_t d,
                         input bit we, input bit ordy, input bit fl,
                         input bit wbv, input reg_addr_t wbd, input word_t wbdata);
        in_valid = v; in_src1 = s1; in_src2 = s2; in_dst = d; in_dst_we = we;
        out_ready = ordy; flush = fl; wb_valid = wbv; wb_dest = wbd; wb_data = wbdata;
    endtask

    // One clock: check the combinational handshake, advance the model, check the output stage.
    task automatic step();
        bit    exp_rdy, acc;
        word_t n_op1, n_op2;
        #1;
        exp_rdy = !flush && (!m_valid || out_ready) && !blocked(in_src1) && !blocked(in_src2)
                  && !(in_dst_we && blocked(in_dst));
        check("in_ready", in_ready, exp_rdy);
        check("rf_addr", {rf_read_addr_1, rf_read_addr_2}, {in_src1, in_src2});
        acc   = in_valid && exp_rdy;
        n_op1 = operand(in_src1);
        n_op2 = operand(in_src2);
        @(posedge clk);
        if (wb_valid) begin
            rf[wb_dest]   = wb_data;
            pend[wb_dest] = 1'b0;
        end
        if (flush && m_valid && m_we) pend[m_dst] = 1'b0;
        if (acc && in_dst_we && in_dst != 0) pend[in_dst] = 1'b1;
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1; m_op1 = n_op1; m_op2 = n_op2; m_dst = in_dst; m_we = in_dst_we;
        end else if (out_ready) m_valid = 1'b0;
        @(negedge clk);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_op1", out_op1, m_op1);
            check("out_op2", out_op2, m_op2);
            check("out_dst", {out_dst_we, out_dst}, {m_we, m_dst});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_ops"}, {out_op1, out_op2}, 32'h0);
        check({tag, "_dst"}, {out_dst_we, out_dst}, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf[i] = word_t'($urandom);
        rf[0] = 16'hFFFF; rf[1] = 16'h0011; rf[2] = 16'h0022;
        model_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Plain read of r1/r2.
        drive(1, 1, 2, 0, 0, 1, 0, 0, 0, 0); step();
        check("basic_op1", out_op1, 16'h0011);
        check("basic_op2", out_op2, 16'h0022);

        // RAW on r3 resolved by writeback of 0xBEEF.
        drive(1, 0, 0, 3, 1, 1, 0, 0, 0, 0); step();
        drive(1, 3, 0, 0, 0, 1, 0, 0, 0, 0); step(); step();
        drive(1, 3, 0, 0, 0, 1, 0, 1, 3, 16'hBEEF); step();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("raw_op1", out_op1, 16'hBEEF);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();

        // r0 sources read as zero; r0 destination never becomes pending.
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
        check("r0_ops", {out_op1, out_op2}, 32'h0);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();

        // Backpressure: output held for 3 cycles with a new instruction waiting.
        drive(1, 1, 2, 0, 0, 1, 0, 0, 0, 0); step();
        drive(1, 2, 1, 6, 1, 0, 0, 0, 0, 0); step(); step(); step();
        drive(1, 2, 1, 6, 1, 1, 0, 0, 0, 0); step();

        // Flush of a held dst=5 instruction releases r5.
        drive(1, 0, 0, 5, 1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        drive(1, 5, 5, 0, 0, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 6, 16'h6666); step();

        // Reset while r4 is pending and the output stage is full.
        drive(1, 0, 0, 4, 1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 4, 4, 0, 0, 1, 0, 0, 0, 0); step();
        check("post_rst_issue", out_valid, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 4, 16'h4444); step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(3, 0) != 0,
                  reg_addr_t'($urandom), reg_addr_t'($urandom), reg_addr_t'($urandom),
                  $urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0,
                  $urandom_range(19, 0) == 0,
                  $urandom_range(2, 0) == 0, reg_addr_t'($urandom), word_t'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
